// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: shared definitions for the edge detector.
//   SYNC_MAX - deepest synchronizer chain the block accepts
//   edge_t   - bundle of the three edge strobes
//   decode() - turns (current, previous) levels into edge strobes
package edge_detect_pkg;

  localparam int SYNC_MAX = 4;

  typedef struct packed {
    logic pos;
    logic neg;
    logic any;
  } edge_t;

  function automatic edge_t decode(input logic cur, input logic prev);
    edge_t e;
    e.pos = cur & ~prev;
    e.neg = ~cur & prev;
    e.any = cur ^ prev;
    return e;
  endfunction

endpackage

// File: rtl/edge_detect_sync.sv
// edge_detect_sync: N-stage reset-to-0 flop chain; wire pass-through when N = 0.
//   clk   - rising-edge clock
//   rst_n - asynchronous reset, active HIGH despite the name
//   d     - raw input
//   q     - synchronized output (d delayed by N clocks)
module edge_detect_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (N == 0) begin : g_pass
      assign q = d;
    end else begin : g_chain
      logic [N-1:0] s;

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          s <= '0;
        end else begin
          s[0] <= d;
          for (int i = 1; i < N; i++) s[i] <= s[i-1];
        end
      end

      assign q = s[N-1];
    end
  endgenerate

endmodule

// File: rtl/edge_detect.sv
// edge_detect: synchronizes a single-bit input and emits registered one-cycle
// strobes on its transitions.
//   clk       - rising-edge clock
//   rst_n     - asynchronous reset, active HIGH despite the name
//   data      - monitored signal (may be asynchronous when SYNC_STAGES >= 2)
//   pos_edge  - one-cycle pulse on a 0->1 transition of the synchronized data
//   neg_edge  - one-cycle pulse on a 1->0 transition
//   data_edge - one-cycle pulse on any transition
module edge_detect
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data,
  output logic pos_edge,
  output logic neg_edge,
  output logic data_edge
);

  generate
    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_MAX) begin : g_bad_param
      $error("edge_detect: SYNC_STAGES=%0d outside 0..%0d", SYNC_STAGES, SYNC_MAX);
    end
  endgenerate

  logic  cur;
  logic  prev;
  edge_t ev;

  edge_detect_sync #(.N(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (data),
    .q    (cur)
  );

  // prev starts at 0, so a high level seen right after reset counts as a rise.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prev <= 1'b0;
      ev   <= '0;
    end else begin
      prev <= cur;
      ev   <= decode(cur, prev);
    end
  end

  assign pos_edge  = ev.pos;
  assign neg_edge  = ev.neg;
  assign data_edge = ev.any;

endmodule

// File: tb/tb_edge_detect.sv
// tb_edge_detect: random + directed stimulus on three depths (0, 2, 4) of the
// edge detector, compared every cycle against a sampled-history model.
module tb_edge_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;

  logic [2:0] pos, neg, de;   // index 0: S=0, 1: S=2, 2: S=4
  int stages [3] = '{0, 2, 4};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_detect #(.SYNC_STAGES(0)) u_s0 (.clk(clk), .rst_n(rst), .data(data),
    .pos_edge(pos[0]), .neg_edge(neg[0]), .data_edge(de[0]));
  edge_detect #(.SYNC_STAGES(2)) u_s2 (.clk(clk), .rst_n(rst), .data(data),
    .pos_edge(pos[1]), .neg_edge(neg[1]), .data_edge(de[1]));
  edge_detect #(.SYNC_STAGES(4)) u_s4 (.clk(clk), .rst_n(rst), .data(data),
    .pos_edge(pos[2]), .neg_edge(neg[2]), .data_edge(de[2]));

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0b expected=%0b", nm, $time, act, exp);
    end
  endtask

  // Model: hist holds the data level sampled at each clock edge since reset,
  // with zeros standing for the pre-reset history. After edge n the strobes of
  // a depth-S detector reflect the step between the samples of edges n-S-1 and n-S.
  logic hist[$];

  task automatic hist_clear();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
  endtask

  initial hist_clear();

  always @(posedge clk) begin
    #1;
    if (rst) begin
      hist_clear();
    end else begin
      hist.push_back(data);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    for (int j = 0; j < 3; j++) begin
      logic c, p;
      c = hist[hist.size() - 1 - stages[j]];
      p = hist[hist.size() - 2 - stages[j]];
      chk($sformatf("pos_s%0d", stages[j]), pos[j], c & ~p);
      chk($sformatf("neg_s%0d", stages[j]), neg[j], p & ~c);
      chk($sformatf("de_s%0d",  stages[j]), de[j],  c ^ p);
    end
  end

  // Advance to 2 time units after the next rising edge: outputs settled,
  // safe to check and to drive.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held with data toggling: outputs must stay low.
    for (int i = 0; i < 6; i++) begin
      cyc();
      data = ~data;
      chk("rst_hold_de2", de[1], 1'b0);
    end
    data = 1'b0;
    cyc();
    rst = 1'b0;                      // released just after edge 0
    cyc(); cyc(); cyc();             // edges 1..3 sample 0
    data = 1'b1;                     // sampled first at edge 4
    cyc();                           // edge 4
    chk("lit_pos_s0_e4", pos[0], 1'b1);
    chk("lit_pos_s2_e4", pos[1], 1'b0);
    cyc();                           // edge 5
    chk("lit_pos_s0_e5", pos[0], 1'b0);
    chk("lit_pos_s2_e5", pos[1], 1'b0);
    cyc();                           // edge 6
    chk("lit_pos_s2_e6", pos[1], 1'b1);
    chk("lit_de_s2_e6",  de[1],  1'b1);
    chk("lit_neg_s2_e6", neg[1], 1'b0);
    data = 1'b0;                     // high for edges 4,5,6; low from edge 7
    cyc();                           // edge 7
    chk("lit_pos_s2_e7", pos[1], 1'b0);
    chk("lit_neg_s0_e7", neg[0], 1'b1);
    cyc();                           // edge 8
    chk("lit_pos_s4_e8", pos[2], 1'b1);
    chk("lit_neg_s2_e8", neg[1], 1'b0);
    cyc();                           // edge 9
    chk("lit_neg_s2_e9", neg[1], 1'b1);
    chk("lit_de_s2_e9",  de[1],  1'b1);
    // Reset between edges truncates the live pulse immediately.
    #3 rst = 1'b1;
    #1;
    chk("lit_async_neg_s2", neg[1], 1'b0);
    chk("lit_async_de_s2",  de[1],  1'b0);
    chk("lit_async_neg_s4", neg[2], 1'b0);
    data = 1'b1;
    cyc(); cyc();
    rst = 1'b0;                      // release with data already high
    cyc();                           // edge 1
    chk("lit_rel_pos_s0", pos[0], 1'b1);
    cyc();                           // edge 2
    chk("lit_rel_pos_s2_e2", pos[1], 1'b0);
    cyc();                           // edge 3
    chk("lit_rel_pos_s2_e3", pos[1], 1'b1);
    cyc();                           // edge 4
    chk("lit_rel_pos_s2_e4", pos[1], 1'b0);
    cyc(); cyc(); cyc();
    chk("lit_rel_quiet_de_s4", de[2], 1'b0);
    // Toggle every cycle: data_edge stays high once the chain is full.
    for (int i = 0; i < 12; i++) begin
      data = ~data;
      cyc();
      if (i >= 3) chk("lit_toggle_de_s2", de[1], 1'b1);
      if (i >= 3) chk("lit_toggle_alt_s2", pos[1] ^ neg[1], 1'b1);
    end
    // Random levels with varying hold times and occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       data = ~data;
        1:       data = $urandom_range(0, 1);
        default: ;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #3 rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
